// File: rtl/sweep_pkg.sv
// Shared types and defaults for the frequency sweep sequencer.
package sweep_pkg;

  localparam int DEFAULT_D_WIDTH  = 8;
  localparam int DEFAULT_DW_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/sweep_ctrl_dwell_timer.sv
// Reloadable down-counter; expire marks the final cycle of a hold period.
module dwell_timer #(
  parameter int DW_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [DW_WIDTH-1:0] load_val,
  output logic                expire
);

  logic [DW_WIDTH-1:0] count;

  // Counter saturates at zero so an unloaded timer never expires spuriously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - DW_WIDTH'(1);
    end
  end

  assign expire = (count == DW_WIDTH'(1));

endmodule

// File: rtl/sweep_ctrl.sv
// Linear frequency sweep sequencer driving the sine generator en/incr inputs.
module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int D_WIDTH  = DEFAULT_D_WIDTH,
  parameter int DW_WIDTH = DEFAULT_DW_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                repeat_mode,
  input  logic [D_WIDTH-1:0]  start_incr,
  input  logic [D_WIDTH-1:0]  stop_incr,
  input  logic [D_WIDTH-1:0]  step_incr,
  input  logic [DW_WIDTH-1:0] dwell,
  output logic                en,
  output logic [D_WIDTH-1:0]  incr,
  output logic                busy,
  output logic                step_pulse,
  output logic                done
);

  state_t              state;
  dir_t                dir_r;
  logic [D_WIDTH-1:0]  start_r;
  logic [D_WIDTH-1:0]  stop_r;
  logic [D_WIDTH-1:0]  step_r;
  logic [DW_WIDTH-1:0] dwell_r;
  logic                repeat_r;

  logic                launch;
  logic                at_end;
  logic                expire;
  logic                tmr_load;
  logic [DW_WIDTH-1:0] tmr_val;
  logic [DW_WIDTH-1:0] eff_dwell;
  logic [D_WIDTH-1:0]  remain;
  logic [D_WIDTH-1:0]  next_incr;

  assign launch    = (state == IDLE) && start && !abort;
  assign eff_dwell = (dwell == '0) ? DW_WIDTH'(1) : dwell;
  assign at_end    = (incr == stop_r) || (step_r == '0);
  assign tmr_load  = launch || ((state == DWELL) && expire && !abort);
  assign tmr_val   = launch ? eff_dwell : dwell_r;

  // Compare against the remaining distance so the step can never overshoot or wrap
  always_comb begin
    remain = (dir_r == DOWN) ? (incr - stop_r) : (stop_r - incr);
    if (remain < step_r) begin
      next_incr = stop_r;
    end else if (dir_r == DOWN) begin
      next_incr = incr - step_r;
    end else begin
      next_incr = incr + step_r;
    end
  end

  dwell_timer #(
    .DW_WIDTH (DW_WIDTH)
  ) u_dwell_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      en         <= 1'b0;
      incr       <= '0;
      busy       <= 1'b0;
      step_pulse <= 1'b0;
      done       <= 1'b0;
      start_r    <= '0;
      stop_r     <= '0;
      step_r     <= '0;
      dwell_r    <= '0;
      repeat_r   <= 1'b0;
      dir_r      <= UP;
    end else begin
      step_pulse <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            start_r    <= start_incr;
            stop_r     <= stop_incr;
            step_r     <= step_incr;
            dwell_r    <= eff_dwell;
            repeat_r   <= repeat_mode;
            dir_r      <= (stop_incr < start_incr) ? DOWN : UP;
            incr       <= start_incr;
            en         <= 1'b1;
            busy       <= 1'b1;
            step_pulse <= 1'b1;
            state      <= DWELL;
          end else begin
            en   <= 1'b0;
            busy <= 1'b0;
          end
        end
        DWELL: begin
          if (abort) begin
            en    <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (expire) begin
            if (!at_end) begin
              incr       <= next_incr;
              step_pulse <= 1'b1;
            end else if (repeat_r) begin
              incr       <= start_r;
              step_pulse <= 1'b1;
            end else begin
              en    <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          en    <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          en    <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
